// File: rtl/tm1638_hex_display.sv
// Purpose : shows a 32-bit word as 8 hex digits plus 8 LEDs on a TM1638 board,
//           refreshing the whole display periodically over the 3-wire serial bus.
// Latency : frame starts on the first edge after reset; each frame is
//           313*CLK_DIV cycles, then REFRESH_CYCLES+1 idle cycles.
// Backpressure: none; value/leds are sampled once per frame, changes mid-frame wait for the next one.
//
// Ports:
//   clkIn      - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   value      - word to display, digit 0 (leftmost) = value[31:28]
//   leds       - discrete LED states, leds[i] drives LED i
//   tm_cs      - TM1638 STB (active low)
//   tm_clk     - TM1638 CLK (idles high)
//   tm_dio     - TM1638 DIO, always driven, idles high
//   busy       - high while a frame is being sent
//   frame_done - one-cycle pulse as the frame finishes
module tm1638_hex_display #(
  parameter int         CLK_DIV        = 16,
  parameter int         REFRESH_CYCLES = 270000,
  parameter logic [2:0] BRIGHTNESS     = 3'd7
) (
  input  logic        clkIn,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic [7:0]  leds,
  output logic        tm_cs,
  output logic        tm_clk,
  inout  wire         tm_dio,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_START,
    S_BIT_LO,
    S_BIT_HI,
    S_STOP,
    S_GAP
  } state_t;

  state_t      state, state_d;
  // One counter serves both the refresh interval (in WAIT) and the
  // CLK_DIV-long phases of every other state.
  logic [31:0] cnt, cnt_d;
  logic [1:0]  txn, txn_d;        // 0: data-write cmd, 1: address + data, 2: display control
  logic [4:0]  byte_idx, byte_d;  // byte within the transaction
  logic [2:0]  bit_idx, bit_d;    // bit within the byte, LSB first
  logic [31:0] value_q;
  logic [7:0]  leds_q;
  logic        snap;
  logic        phase_end;
  logic [4:0]  last_byte;
  logic [3:0]  slot;
  logic [2:0]  digit;
  logic [3:0]  nib;
  logic [7:0]  tx_byte;
  logic        cs_d, clk_d, dio_d, busy_d, done_d;
  logic        dio_q;

  assign tm_dio = dio_q;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h3F;  4'h1: s = 8'h06;  4'h2: s = 8'h5B;  4'h3: s = 8'h4F;
      4'h4: s = 8'h66;  4'h5: s = 8'h6D;  4'h6: s = 8'h7D;  4'h7: s = 8'h07;
      4'h8: s = 8'h7F;  4'h9: s = 8'h6F;  4'hA: s = 8'h77;  4'hB: s = 8'h7C;
      4'hC: s = 8'h39;  4'hD: s = 8'h5E;  4'hE: s = 8'h79;  default: s = 8'h71;
    endcase
    return s;
  endfunction

  // Next-state logic. Outputs are decoded from the *next* state and counters
  // and then registered, so the pins change cleanly on the state edge.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 32'd1;
    txn_d     = txn;
    byte_d    = byte_idx;
    bit_d     = bit_idx;
    snap      = 1'b0;
    done_d    = 1'b0;
    phase_end = (cnt == 32'(CLK_DIV - 1));
    last_byte = (txn == 2'd1) ? 5'd16 : 5'd0;

    case (state)
      S_WAIT: begin
        if (cnt >= 32'(REFRESH_CYCLES)) begin
          state_d = S_START;
          cnt_d   = '0;
          txn_d   = '0;
          byte_d  = '0;
          bit_d   = '0;
          snap    = 1'b1;
        end
      end
      S_START: begin
        if (phase_end) begin
          state_d = S_BIT_LO;
          cnt_d   = '0;
        end
      end
      S_BIT_LO: begin
        if (phase_end) begin
          state_d = S_BIT_HI;
          cnt_d   = '0;
        end
      end
      S_BIT_HI: begin
        if (phase_end) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            bit_d = '0;
            if (byte_idx == last_byte) begin
              state_d = S_STOP;
            end else begin
              byte_d  = byte_idx + 5'd1;
              state_d = S_BIT_LO;
            end
          end else begin
            bit_d   = bit_idx + 3'd1;
            state_d = S_BIT_LO;
          end
        end
      end
      S_STOP: begin
        if (phase_end) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (phase_end) begin
          cnt_d = '0;
          if (txn == 2'd2) begin
            state_d = S_WAIT;
            done_d  = 1'b1;
          end else begin
            txn_d   = txn + 2'd1;
            byte_d  = '0;
            state_d = S_START;
          end
        end
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Byte being shifted: in the data transaction byte 0 is the address
    // command, then digit/LED pairs alternate (odd slot = LED byte).
    slot  = 4'(byte_d - 5'd1);
    digit = slot[3:1];
    nib   = 4'(value_q >> {~digit, 2'b00});
    if (txn_d == 2'd0)       tx_byte = 8'h40;
    else if (txn_d == 2'd2)  tx_byte = {5'b10001, BRIGHTNESS};
    else if (byte_d == 5'd0) tx_byte = 8'hC0;
    else if (!slot[0])       tx_byte = seg7(nib);
    else                     tx_byte = {7'd0, leds_q[digit]};

    cs_d   = 1'b1;
    clk_d  = 1'b1;
    dio_d  = 1'b1;
    busy_d = (state_d != S_WAIT);
    case (state_d)
      S_START, S_STOP: cs_d = 1'b0;
      S_BIT_LO: begin
        cs_d  = 1'b0;
        clk_d = 1'b0;
        dio_d = tx_byte[bit_d];
      end
      S_BIT_HI: begin
        cs_d  = 1'b0;
        dio_d = tx_byte[bit_d];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      cnt        <= 32'(REFRESH_CYCLES);  // first frame starts right after reset
      txn        <= '0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      tm_cs      <= 1'b1;
      tm_clk     <= 1'b1;
      dio_q      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      txn        <= txn_d;
      byte_idx   <= byte_d;
      bit_idx    <= bit_d;
      tm_cs      <= cs_d;
      tm_clk     <= clk_d;
      dio_q      <= dio_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      leds_q  <= '0;
    end else if (snap) begin
      value_q <= value;
      leds_q  <= leds;
    end
  end

endmodule

// File: tb/tb_tm1638_hex_display.sv
// Purpose : self-checking bench for tm1638_hex_display; decodes the serial bus
//           of three differently parameterised instances and checks it
//           against a byte-level model of the frame.
module tb_tm1638_hex_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec  = 0;
  int miss = 0;

  logic [7:0] seg_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // a: frame format / timing / snapshot / reset; b: setup-hold; c: back-to-back
  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [31:0] val_a, val_b, val_c;
  logic [7:0]  led_a, led_b, led_c;
  logic        cs_a, ck_a, busy_a, done_a;
  logic        cs_b, ck_b, busy_b, done_b;
  logic        cs_c, ck_c, busy_c, done_c;
  wire         dio_a, dio_b, dio_c;

  tm1638_hex_display #(.CLK_DIV(2), .REFRESH_CYCLES(10), .BRIGHTNESS(3'd7)) dut_a (
    .clkIn(clk), .rst_n(rst_a), .value(val_a), .leds(led_a), .tm_cs(cs_a),
    .tm_clk(ck_a), .tm_dio(dio_a), .busy(busy_a), .frame_done(done_a));
  tm1638_hex_display #(.CLK_DIV(3), .REFRESH_CYCLES(5), .BRIGHTNESS(3'd7)) dut_b (
    .clkIn(clk), .rst_n(rst_b), .value(val_b), .leds(led_b), .tm_cs(cs_b),
    .tm_clk(ck_b), .tm_dio(dio_b), .busy(busy_b), .frame_done(done_b));
  tm1638_hex_display #(.CLK_DIV(2), .REFRESH_CYCLES(0), .BRIGHTNESS(3'd0)) dut_c (
    .clkIn(clk), .rst_n(rst_c), .value(val_c), .leds(led_c), .tm_cs(cs_c),
    .tm_clk(ck_c), .tm_dio(dio_c), .busy(busy_c), .frame_done(done_c));

  // Reference: the n-th byte of a frame, straight from the frame rules.
  function automatic logic [7:0] model_byte(input logic [31:0] v, input logic [7:0] l,
                                            input logic [2:0] br, input int k);
    int d;
    logic [3:0] n;
    if (k == 0)  return 8'h40;
    if (k == 1)  return 8'hC0;
    if (k == 18) return 8'h88 | {5'd0, br};
    d = (k - 2) / 2;
    n = v[31 - 4*d -: 4];
    if ((k % 2) == 0) return seg_tbl[n];
    return l[d] ? 8'h01 : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- bus decoders (sampled on the falling clkIn edge) ----
  logic [7:0] sh_a, sh_c;
  int         nb_a = 0, nb_c = 0, tb_a = 0, tb_c = 0;
  logic       ckq_a = 1'b1, csq_a = 1'b1, ckq_c = 1'b1, csq_c = 1'b1;
  logic [7:0] bytes_a[$], bytes_c[$];
  int         txl_a[$], txl_c[$];

  always @(negedge clk) begin
    if (csq_a && !cs_a) begin nb_a = 0; tb_a = 0; end
    if (!cs_a && !ckq_a && ck_a) begin
      sh_a = {dio_a, sh_a[7:1]};
      nb_a++;
      if (nb_a == 8) begin bytes_a.push_back(sh_a); nb_a = 0; tb_a++; end
    end
    if (!csq_a && cs_a) txl_a.push_back(tb_a);
    ckq_a = ck_a;
    csq_a = cs_a;
  end

  always @(negedge clk) begin
    if (csq_c && !cs_c) begin nb_c = 0; tb_c = 0; end
    if (!cs_c && !ckq_c && ck_c) begin
      sh_c = {dio_c, sh_c[7:1]};
      nb_c++;
      if (nb_c == 8) begin bytes_c.push_back(sh_c); nb_c = 0; tb_c++; end
    end
    if (!csq_c && cs_c) txl_c.push_back(tb_c);
    ckq_c = ck_c;
    csq_c = cs_c;
  end

  // ---- timing monitors ----
  int busy_run_a = 0, busy_len_a = -1, dprev_a = -1, dlast_a = -1;
  int idle_run_c = 0, idle_len_c = -1, dprev_c = -1, dlast_c = -1;
  always @(negedge clk) begin
    if (busy_a) busy_run_a++;
    else begin
      if (busy_run_a != 0) busy_len_a = busy_run_a;
      busy_run_a = 0;
    end
    if (done_a) begin dprev_a = dlast_a; dlast_a = cyc; end
    if (!busy_c) idle_run_c++;
    else begin
      if (idle_run_c != 0) idle_len_c = idle_run_c;
      idle_run_c = 0;
    end
    if (done_c) begin dprev_c = dlast_c; dlast_c = cyc; end
  end

  // ---- setup/hold and STB-high checker on instance b (CLK_DIV = 3) ----
  int   rise_b = -1000, dchg_b = -1000, csr_b = -1;
  logic ckq_b = 1'b1, dq_b = 1'b1, csq_b = 1'b1;
  always @(negedge clk) begin
    if (rst_b) begin
      if (!cs_b && !ckq_b && ck_b) begin
        rise_b = cyc;
        vec++;
        assert (cyc - dchg_b >= 3) else begin
          miss++;
          $error("FAIL setup_b: dio changed %0d cycles before clk rise, need >= 3", cyc - dchg_b);
        end
      end
      if (!cs_b && dio_b !== dq_b) begin
        dchg_b = cyc;
        vec++;
        assert (cyc - rise_b >= 3) else begin
          miss++;
          $error("FAIL hold_b: dio changed %0d cycles after clk rise, need >= 3", cyc - rise_b);
        end
      end
      if (!csq_b && cs_b) csr_b = cyc;
      if (csq_b && !cs_b && csr_b >= 0) begin
        vec++;
        assert (cyc - csr_b >= 3) else begin
          miss++;
          $error("FAIL stb_high_b: cs high for %0d cycles, need >= 3", cyc - csr_b);
        end
      end
    end
    ckq_b = ck_b;
    dq_b  = dio_b;
    csq_b = cs_b;
  end

  task automatic wait_done(input int which);
    int   n = 0;
    logic d;
    do begin
      @(negedge clk);
      n++;
      d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
    end while (!d && n < 5000);
    chk($sformatf("frame_done_wait_%0d", which), {63'd0, d}, 64'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] got[$], input int tl[$],
                             input logic [31:0] v, input logic [7:0] l, input logic [2:0] br);
    chk({tag, "_ntxn"}, 64'(tl.size()), 64'd3);
    chk({tag, "_t1len"}, 64'(tl[0]), 64'd1);
    chk({tag, "_t2len"}, 64'(tl[1]), 64'd17);
    chk({tag, "_t3len"}, 64'(tl[2]), 64'd1);
    chk({tag, "_nbytes"}, 64'(got.size()), 64'd19);
    for (int k = 0; k < 19; k++)
      chk($sformatf("%s_byte%0d", tag, k), {56'd0, got[k]}, {56'd0, model_byte(v, l, br, k)});
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  l;
    int          n;

    val_a = 32'h0123ABCD; led_a = 8'h81;
    val_b = $urandom;     led_b = 8'($urandom);
    val_c = $urandom;     led_c = 8'($urandom);

    // reset
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs",   {63'd0, cs_a},   64'd1);
    chk("rst_clk",  {63'd0, ck_a},   64'd1);
    chk("rst_dio",  {63'd0, dio_a},  64'd1);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);
    chk("rst_c_cs", {63'd0, cs_c},   64'd1);
    bytes_a.delete(); txl_a.delete(); bytes_c.delete(); txl_c.delete();

    // first frame starts on the first edge after release
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);
    chk("start_busy", {63'd0, busy_a}, 64'd1);
    chk("start_cs",   {63'd0, cs_a},   64'd0);
    chk("start_clk",  {63'd0, ck_a},   64'd1);
    chk("start_dio",  {63'd0, dio_a},  64'd1);

    // frame format with the reference word
    wait_done(0);
    check_frame("fmt", bytes_a, txl_a, 32'h0123ABCD, 8'h81, 3'd7);
    @(negedge clk);
    chk("done_width", {63'd0, done_a}, 64'd0);
    chk("busy_len",   64'(busy_len_a), 64'd626);
    bytes_a.delete(); txl_a.delete();

    // random words, periodic timing
    for (int i = 0; i < 4; i++) begin
      v = $urandom; l = 8'($urandom);
      val_a = v; led_a = l;
      wait_done(0);
      check_frame($sformatf("rnd%0d", i), bytes_a, txl_a, v, l, 3'd7);
      @(negedge clk);
      chk($sformatf("rnd%0d_busy_len", i), 64'(busy_len_a), 64'd626);
      chk($sformatf("rnd%0d_period", i), 64'(dlast_a - dprev_a), 64'd637);
      bytes_a.delete(); txl_a.delete();
    end

    // snapshot: value changes in the middle of T2
    val_a = 32'hFFFFFFFF; led_a = 8'h5A;
    n = 0;
    while (bytes_a.size() < 6 && n < 2000) begin @(negedge clk); n++; end
    chk("snap_reach_t2", 64'(bytes_a.size() >= 6), 64'd1);
    val_a = 32'h00000000;
    wait_done(0);
    check_frame("snap_cur", bytes_a, txl_a, 32'hFFFFFFFF, 8'h5A, 3'd7);
    @(negedge clk);
    bytes_a.delete(); txl_a.delete();
    wait_done(0);
    check_frame("snap_next", bytes_a, txl_a, 32'h00000000, 8'h5A, 3'd7);
    @(negedge clk);
    bytes_a.delete(); txl_a.delete();

    // reset in the 10th bit of T2
    val_a = $urandom;
    n = 0;
    while (!(bytes_a.size() == 2 && nb_a == 1) && n < 2000) begin @(negedge clk); n++; end
    chk("rst_mid_reach", 64'(bytes_a.size() == 2 && nb_a == 1), 64'd1);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("rst_mid_cs",   {63'd0, cs_a},   64'd1);
    chk("rst_mid_clk",  {63'd0, ck_a},   64'd1);
    chk("rst_mid_dio",  {63'd0, dio_a},  64'd1);
    chk("rst_mid_busy", {63'd0, busy_a}, 64'd0);
    repeat (2) @(negedge clk);
    bytes_a.delete(); txl_a.delete();
    v = $urandom; l = 8'($urandom);
    val_a = v; led_a = l;
    rst_a = 1'b1;
    wait_done(0);
    check_frame("after_rst", bytes_a, txl_a, v, l, 3'd7);

    // back-to-back frames, brightness 0
    v = $urandom; l = 8'($urandom);
    val_c = v; led_c = l;
    wait_done(2);
    bytes_c.delete(); txl_c.delete();
    wait_done(2);
    check_frame("b2b", bytes_c, txl_c, v, l, 3'd0);
    chk("b2b_t3_byte", {56'd0, bytes_c[18]}, 64'h88);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle_len", 64'(idle_len_c), 64'd1);
    chk("b2b_period",   64'(dlast_c - dprev_c), 64'd627);

    // let instance b finish at least one more frame under the checker
    wait_done(1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
